// File: rtl/alu_share_sched_if.sv
// ============================================================================
// Module   : alu_share_sched_if
// Purpose  : Request/response bundle between ALU clients and alu_share_sched.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_share_sched_if #(
   parameter int W = 6
);
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [1:0]   req_op;
   logic [W-1:0] A0;
   logic [W-1:0] B0;
   logic [W-1:0] A1;
   logic [W-1:0] B1;
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] RESULT;
   logic         OVERFLOW;
   logic         ZERO;
   logic         NEG;
   logic [7:0]   ovf_count;

   // Client side: requesters plus the response consumer
   modport master (
      output req_valid, req_op, A0, B0, A1, B1, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, RESULT, OVERFLOW, ZERO, NEG, ovf_count
   );

   modport slave (
      input  req_valid, req_op, A0, B0, A1, B1, rsp_ready,
      output req_ready, rsp_valid, rsp_id, RESULT, OVERFLOW, ZERO, NEG, ovf_count
   );
endinterface

`default_nettype wire

// File: rtl/alu_share_sched.sv
// ============================================================================
// Module   : alu_share_sched
// Purpose  : Round-robin scheduler sharing one W-bit add/sub unit between two
//            requesters. ALU_SCHED_OVF_CNT_EN enables the overflow counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_share_sched #(
   parameter int W = 6
) (
   input  wire logic          clock,
   input  wire logic          reset_n,
   alu_share_sched_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;

   logic         r_lp;
   logic         w_grant;
   logic         w_accept;
   logic [1:0]   w_req_ready;
   logic         w_rsp_valid;

   logic         r_op;
   logic [W-1:0] r_a;
   logic [W-1:0] r_b;
   logic         r_id;

   logic [W-1:0] r_result;
   logic         r_ovf;
   logic         r_zero;
   logic         r_neg;
   logic         r_rsp_id;

   logic [W-1:0] w_b_eff;
   logic [W-1:0] w_sum;
   logic         w_ovf;

   // On a tie, the requester that did not win last time goes first
   always_comb begin
      w_grant = 1'b0;
      if (bus.req_valid == 2'b11) begin
         w_grant = ~r_lp;
      end else if (bus.req_valid[1]) begin
         w_grant = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = 2'b00;
      w_rsp_valid = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.req_valid[w_grant]) begin
               w_req_ready[w_grant] = 1'b1;
               w_accept             = 1'b1;
               w_state_nxt          = EXEC;
            end
         end
         EXEC: begin
            w_state_nxt = RESP;
         end
         RESP: begin
            w_rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Subtraction reuses the adder as A + ~B + 1
   always_comb begin
      w_b_eff = r_op ? ~r_b : r_b;
      w_sum   = r_a + w_b_eff + {{(W-1){1'b0}}, r_op};
      if (r_op) begin
         w_ovf = (r_a[W-1] != r_b[W-1]) & (w_sum[W-1] != r_a[W-1]);
      end else begin
         w_ovf = (r_a[W-1] == r_b[W-1]) & (w_sum[W-1] != r_a[W-1]);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_lp     <= 1'b1;
         r_op     <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_id     <= 1'b0;
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
         r_neg    <= 1'b0;
         r_rsp_id <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op <= bus.req_op[w_grant];
            r_a  <= w_grant ? bus.A1 : bus.A0;
            r_b  <= w_grant ? bus.B1 : bus.B0;
            r_id <= w_grant;
            r_lp <= w_grant;
         end
         if (r_state == EXEC) begin
            r_result <= w_sum;
            r_ovf    <= w_ovf;
            r_zero   <= (w_sum == '0);
            r_neg    <= w_sum[W-1];
            r_rsp_id <= r_id;
         end
      end
   end

`ifdef ALU_SCHED_OVF_CNT_EN
   logic [7:0] r_ovf_count;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_ovf_count <= 8'd0;
      end else if ((r_state == EXEC) && w_ovf && (r_ovf_count != 8'hFF)) begin
         r_ovf_count <= r_ovf_count + 8'd1;
      end
   end

   assign bus.ovf_count = r_ovf_count;
`else
   assign bus.ovf_count = 8'd0;
`endif

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.RESULT    = r_result;
   assign bus.OVERFLOW  = r_ovf;
   assign bus.ZERO      = r_zero;
   assign bus.NEG       = r_neg;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_sched.sv
// ============================================================================
// Module   : tb_alu_share_sched
// Purpose  : Scoreboard bench for alu_share_sched (honours ALU_SCHED_OVF_CNT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_share_sched;

   localparam int W = 6;
`ifdef ALU_SCHED_OVF_CNT_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   alu_share_sched_if #(.W(W)) bus ();

   alu_share_sched #(.W(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic         id;
      logic [W-1:0] result;
      logic         ovf;
      logic         zero;
      logic         neg;
   } exp_t;

   exp_t sb[$];
   exp_t pe;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference computed with signed integer arithmetic and range test
   function automatic exp_t model(input logic id, input logic op,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   sa;
      int   sbv;
      int   r;
      sa       = $signed(a);
      sbv      = $signed(b);
      r        = op ? (sa - sbv) : (sa + sbv);
      e.id     = id;
      e.result = r[W-1:0];
      e.ovf    = (r > (2**(W-1)) - 1) || (r < -(2**(W-1)));
      e.zero   = (e.result == '0);
      e.neg    = e.result[W-1];
      return e;
   endfunction

   always @(negedge clock) begin
      if (reset_n) begin
         for (int i = 0; i < 2; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
               sb.push_back(model(1'(i), bus.req_op[i],
                                  (i == 1) ? bus.A1 : bus.A0,
                                  (i == 1) ? bus.B1 : bus.B0));
            end
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               pe = sb.pop_front();
               check("rsp_id",   bus.rsp_id,   pe.id);
               check("RESULT",   bus.RESULT,   pe.result);
               check("OVERFLOW", bus.OVERFLOW, pe.ovf);
               check("ZERO",     bus.ZERO,     pe.zero);
               check("NEG",      bus.NEG,      pe.neg);
            end
         end
      end
   end

   task automatic wait_accept(input int id, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (bus.req_valid[id] && bus.req_ready[id]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clock);
      check("drain", sb.size(), 32'd0);
   endtask

   task automatic set_req(input int id, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (id == 0) begin
         bus.A0 = a;
         bus.B0 = b;
      end else begin
         bus.A1 = a;
         bus.B1 = b;
      end
      bus.req_op[id]    = op;
      bus.req_valid[id] = 1'b1;
   endtask

   task automatic do_op(input int id, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok;
      @(posedge clock); #1;
      set_req(id, op, a, b);
      wait_accept(id, ok);
      @(posedge clock); #1;
      bus.req_valid[id] = 1'b0;
      if (ok) begin
         @(negedge clock);
         check("lat_exec_rsp_valid", bus.rsp_valid, 32'd0);
         @(negedge clock);
         check("lat_resp_rsp_valid", bus.rsp_valid, 32'd1);
      end
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset_n       = 1'b0;
      bus.req_valid = 2'b00;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      sb.delete();
   endtask

   task automatic run_stream(input int n);
      bit ok;
      int cnt;
      cnt = 0;
      @(posedge clock); #1;
      set_req(0, 1'b1, 6'b010011, 6'b101111);
      while (cnt < n) begin
         wait_accept(0, ok);
         if (!ok) break;
         cnt++;
      end
      @(posedge clock); #1;
      bus.req_valid = 2'b00;
      drain();
   endtask

   initial begin
      bit ok;
      int prev;
      bus.req_valid = 2'b00;
      bus.req_op    = 2'b00;
      bus.A0        = '0;
      bus.B0        = '0;
      bus.A1        = '0;
      bus.B1        = '0;
      bus.rsp_ready = 1'b1;

      // Reset values
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_req_ready", bus.req_ready, 32'd0);
      check("rst_rsp_valid", bus.rsp_valid, 32'd0);
      check("rst_rsp_id",    bus.rsp_id,    32'd0);
      check("rst_RESULT",    bus.RESULT,    32'd0);
      check("rst_flags",     {bus.OVERFLOW, bus.ZERO, bus.NEG}, 32'd0);
      check("rst_ovf_count", bus.ovf_count, 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      // Directed vectors
      do_op(0, 1'b1, 6'b010011, 6'b101111);
      do_op(1, 1'b1, 6'b011001, 6'b011001);
      do_op(0, 1'b1, 6'b101101, 6'b010001);
      do_op(1, 1'b0, 6'b000101, 6'b000011);
      for (int k = 0; k < 10; k++) begin
         do_op(k % 2, 1'($urandom_range(1)), 6'($urandom), 6'($urandom));
      end
      drain();

      // Tie from reset: alternating grants, one accept every 3 cycles
      do_reset();
      @(posedge clock); #1;
      set_req(0, 1'b0, 6'd1, 6'd2);
      set_req(1, 1'b1, 6'd3, 6'd4);
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         ok = 1'b0;
         for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            if ((bus.req_valid & bus.req_ready) != 2'b00) begin
               ok = 1'b1;
               break;
            end
         end
         check("rr_accept", ok, 32'd1);
         check("rr_grant", bus.req_ready, (k % 2 == 0) ? 32'd1 : 32'd2);
         if (k > 0) check("rr_gap", cyc - prev, 32'd3);
         prev = cyc;
      end
      @(posedge clock); #1;
      bus.req_valid = 2'b00;
      drain();

      // Backpressure in RESP with a pending request from requester 1
      @(posedge clock); #1;
      bus.rsp_ready = 1'b0;
      set_req(0, 1'b1, 6'b010011, 6'b101111);
      wait_accept(0, ok);
      @(posedge clock); #1;
      bus.req_valid[0] = 1'b0;
      set_req(1, 1'b0, 6'b000101, 6'b000011);
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         check("bp_rsp_valid", bus.rsp_valid, 32'd1);
         check("bp_RESULT",    bus.RESULT,    32'h24);
         check("bp_rsp_id",    bus.rsp_id,    32'd0);
         check("bp_req_ready", bus.req_ready, 32'd0);
      end
      @(posedge clock); #1;
      bus.rsp_ready = 1'b1;
      @(negedge clock);
      check("bp_take_req_ready", bus.req_ready, 32'd0);
      @(negedge clock);
      check("bp_next_accept", bus.req_ready, 32'd2);
      @(posedge clock); #1;
      bus.req_valid = 2'b00;
      drain();

      // Reset while in EXEC discards the operation
      @(posedge clock); #1;
      set_req(0, 1'b1, 6'b101101, 6'b010001);
      wait_accept(0, ok);
      @(posedge clock); #1;
      reset_n       = 1'b0;
      bus.req_valid = 2'b00;
      @(negedge clock);
      check("rx_exec_rsp_valid", bus.rsp_valid, 32'd0);
      @(negedge clock);
      check("rx_rsp_valid", bus.rsp_valid, 32'd0);
      check("rx_RESULT",    bus.RESULT,    32'd0);
      check("rx_rsp_id",    bus.rsp_id,    32'd0);
      check("rx_flags",     {bus.OVERFLOW, bus.ZERO, bus.NEG}, 32'd0);
      check("rx_req_ready", bus.req_ready, 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      sb.delete();
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check("rx_no_pulse", bus.rsp_valid, 32'd0);
      end

      // Overflow statistic
      do_reset();
      run_stream(3);
      check("ovf_count_3", bus.ovf_count, OVF_EN ? 32'd3 : 32'd0);
      run_stream(257);
      check("ovf_count_sat", bus.ovf_count, OVF_EN ? 32'd255 : 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/alu_share_sched.md
# alu_share_sched

Arbitrating scheduler sharing one 6-bit two's-complement add/sub datapath between two requesters. Accepts operations over per-requester valid/ready handshakes, grants round-robin, and executes one operation at a time. Returns a registered result with overflow/zero/negative flags and requester ID over a single response handshake. Sits between the ALU front-end clients and the add/sub unit. It is the only block permitted to drive that unit.

## Interface
Parameters:
- `W`, 6: operand/result width in bits; flag logic uses bit `W-1` as the sign bit.

Ports:
- `clock` input, 1 bit: single clock; all state updates on rising edge.
- `reset_n` input, 1 bit: synchronous, active-low reset, sampled on rising edge of `clock`.
- `req_valid[1:0]` input, 2 bits: requester i has an operation pending.
- `req_ready[1:0]` output, 2 bits: requester i's operation is accepted this cycle.
- `req_op[1:0]` input, 2 bits: per requester, 0 = add (A+B), 1 = sub (A−B).
- `A0`, `B0`, `A1`, `B1` input, `W` bits each: operands of requester 0 and requester 1.
- `rsp_valid` output, 1 bit: response registers hold a result.
- `rsp_ready` input, 1 bit: consumer takes the response.
- `rsp_id` output, 1 bit: requester that issued the result.
- `RESULT` output, `W` bits: sum or difference, modulo 2^W.
- `OVERFLOW`, `ZERO`, `NEG` output, 1 bit each: result flags.
- `ovf_count` output, 8 bits: overflow statistic (see Configuration).

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Arbiter picks `grant` from `req_valid` and the last-grant pointer `lp`.
  - If exactly one requester is valid, that requester wins.
  - If both are valid, the requester ≠ `lp` wins.
  - `lp` resets to 1, so requester 0 wins the first tie.
  - `req_ready[grant]` = 1 combinationally; the other bit = 0.
  - On `req_valid[grant]&req_ready[grant]`: latch op, A, B and grant; set `lp` = grant; go to EXEC.
- EXEC:
  - Drive the latched operands into the add/sub unit. Sub is computed as A + ~B + 1.
  - Register RESULT, flags and `rsp_id`; go to RESP.
- RESP:
  - `rsp_valid` = 1. On `rsp_ready` = 1, go to IDLE.
  - RESULT, flags and `rsp_id` are held stable while `rsp_ready` = 0.
- `req_ready` = 2'b00 in EXEC and RESP.
- Flags:
  - Add: OVERFLOW = (A[W-1]==B[W-1]) & (R[W-1]!=A[W-1]).
  - Sub: OVERFLOW = (A[W-1]!=B[W-1]) & (R[W-1]!=A[W-1]).
  - ZERO = (R==0). NEG = R[W-1]. No carry-out is exported.
- Requesters must hold `req_valid` and operands stable until accepted. `req_valid` must not depend on `req_ready`.

## Timing
- Accept on edge E0. RESULT and `rsp_valid` are registered on edge E1, so they are visible in the cycle after E1 (2-edge latency).
- With `rsp_ready` tied high, throughput is 1 operation per 3 cycles.
- Response taken on edge Ek → IDLE. A new accept is possible at Ek+1.
- No overlap: a request arriving during EXEC or RESP waits.
- Reset values:
  - state = IDLE, `lp` = 1.
  - `req_ready` = 00, `rsp_valid` = 0, `rsp_id` = 0.
  - RESULT = 0, OVERFLOW = 0, ZERO = 0, NEG = 0, `ovf_count` = 0.
- Reset in EXEC or RESP discards the pending operation and response, with no `rsp_valid` pulse.
- A request whose `req_valid` falls before acceptance is not executed.

## Configuration
- `ALU_SCHED_OVF_CNT_EN` defined:
  - `ovf_count` increments by 1 each time a result with OVERFLOW = 1 is registered in EXEC.
  - It saturates at 255 and clears only on reset.
- `ALU_SCHED_OVF_CNT_EN` undefined:
  - The counter logic is absent and `ovf_count` is constant 8'd0.
  - All other behaviour is identical.

## Test plan
- Sub, requester 0: A0 = 010011 (19), B0 = 101111 (−17) → RESULT = 100100, OVERFLOW = 1, NEG = 1, ZERO = 0, `rsp_id` = 0, `rsp_valid` 2 edges after accept.
- Sub, requester 1: A1 = 011001, B1 = 011001 → RESULT = 000000, ZERO = 1, OVERFLOW = 0, NEG = 0, `rsp_id` = 1.
- Sub: 101101 (−19) − 010001 (17) → RESULT = 011100, OVERFLOW = 1. Add: 000101 + 000011 → 001000, all flags 0.
- Both `req_valid` high continuously from reset, `rsp_ready` = 1 → grants alternate 0, 1, 0, 1; `rsp_id` sequence 0, 1, 0, 1; one accept every 3 cycles.
- `rsp_ready` held 0 for 4 cycles in RESP → RESULT and `rsp_id` stable, `req_ready` = 00 throughout; the pending request is accepted the cycle after `rsp_ready` = 1.
- `reset_n` = 0 during EXEC → next cycle IDLE, `rsp_valid` = 0, all outputs at reset values. With `ALU_SCHED_OVF_CNT_EN`: 3 overflow ops → `ovf_count` = 3; 260 overflow ops → 255.
